grid_display_scan: RTL and testbench
====================================

// Module: grid_display_scan
// PURPOSE
//  Consumer end of the Game-of-Life grid bus. Accepts each evolved 64-bit generation via a valid/ready
//  handshake and scans it onto a row-multiplexed LED matrix, one row at a time, with blanking.
//  Double-buffered: a new generation is taken only at a frame boundary, so a frame never tears.
//  Sits between the life core's grid output and the board's matrix drivers.
// PARAMETERS
//  ROWS   8     matrix rows
//  COLS   8     matrix columns; grid width = ROWS*COLS
//  DWELL  1024  clk cycles each row is driven (>=1)
//  BLANK  4     clk cycles all rows are off before each row (>=0; 0 = no blanking)
// PORTS
//  clk         in   1          system clock, rising edge
//  reset       in   1          asynchronous, active-low reset
//  enable      in   1          1 = scan, 0 = matrix dark
//  grid_in     in   ROWS*COLS  generation; bit r*COLS+c = cell (row r, col c)
//  grid_valid  in   1          grid_in is valid this cycle
//  grid_ready  out  1          block can accept grid_in this cycle
//  row_sel     out  ROWS       one-hot row drive, active-high
//  col_data    out  COLS       column data for the driven row, 1 = LED on
//  frame_done  out  1          one-cycle pulse at end of last row's DWELL
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, row=0, counters=0, active and pending buffers=0, pending_full=0;
//   row_sel=0, col_data=0, frame_done=0. grid_ready reads 1.
//  Handshake: grid_ready = ~pending_full (combinational). Transfer when grid_valid & grid_ready at a
//   rising edge: pending<=grid_in, pending_full<=1. grid_in not sampled otherwise.
//  Swap: pending->active, pending_full<=0, at (a) the frame_done cycle's edge, or (b) any edge while IDLE.
//   A swap and a capture never coincide (capture requires pending_full=0; swap requires it set).
//  FSM states: IDLE, BLANKING, DRIVE. All outputs registered.
//   IDLE: outputs 0. enable=1 -> BLANKING (row 0), or directly DRIVE (row 0) if BLANK=0.
//   BLANKING: row_sel=0, col_data=0 for exactly BLANK cycles -> DRIVE.
//   DRIVE: row_sel=1<<row, col_data=active[row*COLS +: COLS] for exactly DWELL cycles.
//    Last DRIVE cycle of row<ROWS-1: row++ -> BLANKING (or DRIVE if BLANK=0).
//    Last DRIVE cycle of row ROWS-1: frame_done=1 for one cycle coinciding with that last DRIVE cycle;
//     row wraps to 0; swap per rule (a); new data visible from row 0 of next frame.
//  Frame period = ROWS*(BLANK+DWELL) cycles; first row_sel=1 appears BLANK+1 cycles after enable rises.
//  col_data is sampled from active when each row starts; a swap never changes a row in flight.
//  enable=0 in any state: next edge -> IDLE, row=0, counters=0, outputs 0, no frame_done.
//   Pending buffer is retained and swapped in while IDLE.
//  Counter widths: $clog2(DWELL+1), $clog2(BLANK+1) (min 1), $clog2(ROWS); no overflow paths.
//  Async reset mid-DRIVE: outputs drop to 0 immediately (not clock-gated); buffers cleared.
// TESTING  (ROWS=8, COLS=8, DWELL=4, BLANK=2)
//  1 Assert reset mid-clock -> row_sel,col_data,frame_done=0 at once; grid_ready=1 after release.
//  2 enable=0, load 64'h8000_0000_0000_00A5; enable=1 -> 2 cycles dark, row_sel=8'h01 col_data=8'hA5
//    for 4 cycles, 2 dark, rows 1..6 col_data=0, row 7 (row_sel=8'h80) col_data=8'h80.
//  3 Free-run -> frame_done high exactly 1 cycle every 48 cycles, coinciding with the last row-7 cycle.
//  4 Load 64'hFF mid-frame -> grid_ready=0 until frame_done; the remaining rows of the current frame are
//    unchanged; the next frame shows row 0=8'hFF; a second grid_valid while pending is not accepted.
//  5 Drop enable during row 3 DRIVE -> next cycle all outputs 0, no frame_done; re-enable -> restarts
//    at row 0 after 2 blank cycles.
//  6 BLANK=0 build -> rows back-to-back, row_sel never 0 between rows, frame period 32.

Source files
------------

// File: rtl/grid_display_scan.sv
// Row-multiplexed LED matrix scanner with a double-buffered grid input; outputs registered, one row per BLANK+DWELL cycles.
// grid_ready drops while a generation is pending and rises once it has been swapped in at a frame boundary.
module grid_display_scan #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int DWELL = 1024,
    parameter int BLANK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] grid_in,
    input  logic                 grid_valid,
    output logic                 grid_ready,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_data,
    output logic                 frame_done
);

    localparam int DW = $clog2(DWELL + 1);
    localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DWELL - 1);
    localparam logic [BW-1:0] B_LAST = BW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, BLANKING, DRIVE} state_t;

    state_t                 state_q, state_d;
    logic [RW-1:0]          row_q, row_d;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [ROWS-1:0]        row_sel_d;
    logic [COLS-1:0]        col_data_d;
    logic                   frame_done_d;
    logic [ROWS*COLS-1:0]   active_q, pending_q, active_nx;
    logic                   pending_full_q;
    logic                   swap, capture, start_row;

    assign grid_ready = ~pending_full_q;
    assign capture    = grid_valid & ~pending_full_q;
    assign swap       = pending_full_q & (frame_done | (state_q == IDLE));
    // A row starting on the swap edge (BLANK=0 wrap, or leaving IDLE) must see the new generation.
    assign active_nx  = swap ? pending_q : active_q;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        dcnt_d       = dcnt_q;
        bcnt_d       = bcnt_q;
        row_sel_d    = row_sel;
        col_data_d   = col_data;
        start_row    = 1'b0;
        frame_done_d = 1'b0;
        if (!enable) begin
            state_d    = IDLE;
            row_d      = '0;
            dcnt_d     = '0;
            bcnt_d     = '0;
            row_sel_d  = '0;
            col_data_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    row_d = '0;
                    if (BLANK == 0) begin
                        start_row = 1'b1;
                    end else begin
                        state_d    = BLANKING;
                        bcnt_d     = '0;
                        row_sel_d  = '0;
                        col_data_d = '0;
                    end
                end
                BLANKING: begin
                    if (bcnt_q == B_LAST) start_row = 1'b1;
                    else                  bcnt_d    = bcnt_q + BW'(1);
                end
                DRIVE: begin
                    if (dcnt_q == D_LAST) begin
                        row_d = (row_q == R_LAST) ? '0 : row_q + RW'(1);
                        if (BLANK == 0) begin
                            start_row = 1'b1;
                        end else begin
                            state_d    = BLANKING;
                            bcnt_d     = '0;
                            row_sel_d  = '0;
                            col_data_d = '0;
                        end
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            if (start_row) begin
                state_d    = DRIVE;
                dcnt_d     = '0;
                row_sel_d  = ROWS'(1) << row_d;
                col_data_d = active_nx[row_d*COLS +: COLS];
            end
            frame_done_d = (state_d == DRIVE) && (row_d == R_LAST) && (dcnt_d == D_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            row_q          <= '0;
            dcnt_q         <= '0;
            bcnt_q         <= '0;
            row_sel        <= '0;
            col_data       <= '0;
            frame_done     <= 1'b0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            dcnt_q     <= dcnt_d;
            bcnt_q     <= bcnt_d;
            row_sel    <= row_sel_d;
            col_data   <= col_data_d;
            frame_done <= frame_done_d;
            if (swap) begin
                active_q       <= pending_q;
                pending_full_q <= 1'b0;
            end
            if (capture) begin
                pending_q      <= grid_in;
                pending_full_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_grid_display_scan.sv
// Directed bench for grid_display_scan: BLANK=2 instance for the main scenarios, BLANK=0 instance for back-to-back rows.
module tb_grid_display_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, grid_valid, grid_ready, frame_done;
    logic [63:0] grid_in;
    logic [7:0]  row_sel, col_data;
    logic        en0, gv0, gr0, fd0;
    logic [63:0] gi0;
    logic [7:0]  rs0, cd0;

    int          checks = 0;
    int          failures = 0;
    int          ph = 0;
    logic [63:0] m_active, m_pending;
    bit          m_pfull;

    always #5 clk = ~clk;

    grid_display_scan #(.ROWS(8), .COLS(8), .DWELL(4), .BLANK(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .grid_in(grid_in), .grid_valid(grid_valid),
        .grid_ready(grid_ready), .row_sel(row_sel), .col_data(col_data), .frame_done(frame_done)
    );

    grid_display_scan #(.ROWS(8), .COLS(8), .DWELL(4), .BLANK(0)) dut0 (
        .clk(clk), .reset(reset), .enable(en0), .grid_in(gi0), .grid_valid(gv0),
        .grid_ready(gr0), .row_sel(rs0), .col_data(cd0), .frame_done(fd0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of the BLANK=2 scan: 2 dark cycles then 4 drive cycles per row, 48-cycle frame.
    task automatic step_check(input string name);
        logic [16:0] exp_v, got_v;
        int r, p;
        tick();
        r = ph / 6;
        p = ph % 6;
        exp_v = '0;
        if (p >= 2) exp_v = {8'(1 << r), m_active[r*8 +: 8], (ph == 47)};
        got_v = {row_sel, col_data, frame_done};
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s ph=%0d {row_sel,col_data,frame_done} got=%h exp=%h", name, ph, got_v, exp_v);
        end
        if (ph == 47 && m_pfull) begin
            m_active = m_pending;
            m_pfull  = 1'b0;
        end
        ph = (ph + 1) % 48;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({row_sel, col_data, frame_done} !== 17'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {row_sel, col_data, frame_done});
        end
        checks++;
        if (grid_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", grid_ready);
        end
        tick();
        reset = 1'b1;
        tick();
        grid_in = '1;
        grid_valid = 1'b1;
        tick();
        grid_valid = 1'b0;
        tick();
        enable = 1'b1;
        repeat (3) tick();
        checks++;
        if ({row_sel, col_data} !== 16'h01FF) begin
            failures++;
            $display("FAIL pre_reset_drive got=%h exp=01ff", {row_sel, col_data});
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({row_sel, col_data, frame_done} !== 17'h0) begin
            failures++;
            $display("FAIL async_reset_outputs got=%h exp=0", {row_sel, col_data, frame_done});
        end
        tick();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        checks++;
        if ({grid_ready, row_sel, col_data, frame_done} !== 18'h20000) begin
            failures++;
            $display("FAIL post_reset got=%h exp=20000", {grid_ready, row_sel, col_data, frame_done});
        end
    endtask

    task automatic test_first_frame();
        grid_in    = 64'h8000_0000_0000_00A5;
        grid_valid = 1'b1;
        tick();
        grid_valid = 1'b0;
        tick();
        enable   = 1'b1;
        m_active = 64'h8000_0000_0000_00A5;
        m_pfull  = 1'b0;
        ph       = 0;
        for (int i = 0; i < 48; i++) step_check("first_frame");
    endtask

    task automatic test_frame_period();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 96; i++) begin
            step_check("free_run");
            if (frame_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL frame_done_count got=%0d exp=2", pulses);
        end
    endtask

    task automatic test_midframe_load();
        while (ph != 20) step_check("pre_load");
        checks++;
        if (grid_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_load got=%b exp=1", grid_ready);
        end
        grid_in    = 64'h0000_0000_0000_00FF;
        grid_valid = 1'b1;
        step_check("load_cycle");
        m_pending  = 64'h0000_0000_0000_00FF;
        m_pfull    = 1'b1;
        grid_in    = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 3; i++) begin
            step_check("second_valid");
            checks++;
            if (grid_ready !== 1'b0) begin
                failures++;
                $display("FAIL ready_while_pending got=%b exp=0", grid_ready);
            end
        end
        grid_valid = 1'b0;
        while (ph != 0) step_check("rest_of_frame");
        checks++;
        if (grid_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_at_frame_done got=%b exp=0", grid_ready);
        end
        step_check("swap_edge");
        checks++;
        if (grid_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_swap got=%b exp=1", grid_ready);
        end
        while (ph != 0) step_check("new_frame");
    endtask

    task automatic test_enable_drop();
        while (ph != 22) step_check("to_row3");
        enable = 1'b0;
        tick();
        checks++;
        if ({row_sel, col_data, frame_done} !== 17'h0) begin
            failures++;
            $display("FAIL enable_drop got=%h exp=0", {row_sel, col_data, frame_done});
        end
        grid_in    = 64'h0000_0000_0000_0100;
        grid_valid = 1'b1;
        tick();
        grid_valid = 1'b0;
        tick();
        checks++;
        if ({grid_ready, row_sel, col_data, frame_done} !== 18'h20000) begin
            failures++;
            $display("FAIL idle_swap got=%h exp=20000", {grid_ready, row_sel, col_data, frame_done});
        end
        enable   = 1'b1;
        m_active = 64'h0000_0000_0000_0100;
        m_pfull  = 1'b0;
        ph       = 0;
        for (int i = 0; i < 48; i++) step_check("restart");
        enable = 1'b0;
    endtask

    task automatic test_no_blank();
        logic [16:0] exp_v;
        int r;
        gi0 = 64'h0807_0605_0403_0201;
        gv0 = 1'b1;
        tick();
        gv0 = 1'b0;
        tick();
        checks++;
        if (gr0 !== 1'b1) begin
            failures++;
            $display("FAIL nb_ready got=%b exp=1", gr0);
        end
        en0 = 1'b1;
        for (int t = 0; t < 64; t++) begin
            tick();
            r = (t % 32) / 4;
            exp_v = {8'(1 << r), 8'(r + 1), ((t % 32) == 31)};
            checks++;
            if ({rs0, cd0, fd0} !== exp_v) begin
                failures++;
                $display("FAIL no_blank t=%0d got=%h exp=%h", t, {rs0, cd0, fd0}, exp_v);
            end
        end
        en0 = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        grid_valid = 1'b0;
        grid_in    = '0;
        en0        = 1'b0;
        gv0        = 1'b0;
        gi0        = '0;
        m_active   = '0;
        m_pending  = '0;
        m_pfull    = 1'b0;
        test_reset();
        test_first_frame();
        test_frame_period();
        test_midframe_load();
        test_enable_drop();
        test_no_blank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
